// File: rtl/boreal_vns_pkg.sv
// Shared types and defaults for the VNS pulse-train sequencer.
// The soft-start feature is enabled by defining VNS_RAMP_EN.
package boreal_vns_pkg;

    localparam int unsigned AMP_W_DEF = 12;
    localparam logic [11:0] BRAKE_AMP_CAP_DEF = 12'h100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CATH,
        ST_IPG,
        ST_ANOD,
        ST_REST
    } vns_state_e;

    // Clocks left in a pulse period once both phases and the gap are done
    function automatic int unsigned rest_cycles(input int unsigned period,
                                                input int unsigned pw,
                                                input int unsigned ipg);
        return period - 2 * pw - ipg;
    endfunction

endpackage

// File: rtl/boreal_brake_holdoff.sv
// Vagus Brake flag: sets one clock after the guard is seen high, clears after
// HOLDOFF_CYCLES consecutive guard-low clocks.
module boreal_brake_holdoff #(
    parameter int unsigned HOLDOFF_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic guard_i,
    output logic brake_active_o
);

    localparam int unsigned HO_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

    logic [HO_W-1:0] cnt_q, cnt_d;
    logic            brake_q, brake_d;

    always_comb begin
        cnt_d   = cnt_q;
        brake_d = brake_q;
        if (guard_i) begin
            brake_d = 1'b1;
            cnt_d   = '0;
        end else if (brake_q) begin
            if (cnt_q == HO_LAST) begin
                brake_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + HO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            brake_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            brake_q <= brake_d;
        end
    end

    assign brake_active_o = brake_q;

endmodule

// File: rtl/boreal_vns_pulse_ctrl.sv
// Biphasic VNS pulse-train sequencer with Vagus Brake abort/amplitude cap.
// Optional soft start (per-pulse amplitude ramp) under `define VNS_RAMP_EN.
module boreal_vns_pulse_ctrl
    import boreal_vns_pkg::*;
#(
    parameter int unsigned PW_CYCLES      = 200,
    parameter int unsigned IPG_CYCLES     = 20,
    parameter int unsigned PERIOD_CYCLES  = 5000,
    parameter int unsigned AMP_W          = AMP_W_DEF,
    parameter logic [AMP_W-1:0] BRAKE_AMP_CAP = AMP_W'(BRAKE_AMP_CAP_DEF),
    parameter int unsigned HOLDOFF_CYCLES = 1024,
    parameter int unsigned RAMP_STEP      = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stim_req,
    input  logic [AMP_W-1:0] stim_amp,
    input  logic [7:0]       stim_count,
    input  logic             ad_guard_active,
    output logic             cath_en,
    output logic             anod_en,
    output logic [AMP_W-1:0] dac_code,
    output logic             busy,
    output logic             stim_ack,
    output logic             train_done,
    output logic             train_aborted,
    output logic             brake_active
);

    localparam int unsigned PH_W = $clog2(PERIOD_CYCLES + 1);
    localparam logic [PH_W-1:0] PW_LAST   = PH_W'(PW_CYCLES - 1);
    localparam logic [PH_W-1:0] IPG_LAST  = PH_W'(IPG_CYCLES - 1);
    localparam logic [PH_W-1:0] REST_LAST =
        PH_W'(rest_cycles(PERIOD_CYCLES, PW_CYCLES, IPG_CYCLES) - 1);

    if (PW_CYCLES < 1 || IPG_CYCLES < 1 || RAMP_STEP < 1 ||
        PERIOD_CYCLES < 2 * PW_CYCLES + IPG_CYCLES + 1) begin : g_bad_cfg
        $error("boreal_vns_pulse_ctrl: illegal timing parameters");
    end

    vns_state_e       state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [7:0]       pulse_q, pulse_d;
    logic [7:0]       count_q, count_d;
    logic [AMP_W-1:0] amp_q, amp_d;
    logic [AMP_W-1:0] phase_amp_d;
    logic             abort_q, abort_d;
    logic             brake_dly_q;
    logic             brake_rise_c;
    logic             start_c;
    logic             ack_d, done_d, aborted_d;

    boreal_brake_holdoff #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_holdoff (
        .clk           (clk),
        .rst           (rst),
        .guard_i       (ad_guard_active),
        .brake_active_o(brake_active)
    );

    assign brake_rise_c = brake_active & ~brake_dly_q;

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q + PH_W'(1);
        pulse_d   = pulse_q;
        count_d   = count_q;
        amp_d     = amp_q;
        abort_d   = abort_q | (brake_rise_c && state_q != ST_IDLE);
        start_c   = 1'b0;
        ack_d     = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ph_d    = '0;
                abort_d = 1'b0;
                if (stim_req) begin
                    ack_d = 1'b1;
                    if (stim_count == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        count_d = stim_count;
                        amp_d   = (brake_active && stim_amp > BRAKE_AMP_CAP) ?
                                  BRAKE_AMP_CAP : stim_amp;
                        pulse_d = '0;
                        start_c = 1'b1;
                        state_d = ST_CATH;
                    end
                end
            end
            ST_CATH: begin
                if (ph_q == PW_LAST) begin
                    ph_d    = '0;
                    state_d = ST_IPG;
                end
            end
            ST_IPG: begin
                if (ph_q == IPG_LAST) begin
                    ph_d    = '0;
                    state_d = ST_ANOD;
                end
            end
            ST_ANOD: begin
                // Anodic phase always runs to completion for charge balance
                if (ph_q == PW_LAST) begin
                    ph_d = '0;
                    if (abort_d) begin
                        abort_d   = 1'b0;
                        aborted_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_REST;
                    end
                end
            end
            ST_REST: begin
                if (abort_d) begin
                    ph_d      = '0;
                    abort_d   = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (ph_q == REST_LAST) begin
                    ph_d = '0;
                    if (pulse_q + 8'd1 == count_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        pulse_d = pulse_q + 8'd1;
                        start_c = 1'b1;
                        state_d = ST_CATH;
                    end
                end
            end
            default: begin
                ph_d    = '0;
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef VNS_RAMP_EN
    logic [AMP_W-1:0] pulse_amp_q;

    // min(base, (k+1)*RAMP_STEP) with the product saturated to the DAC range
    function automatic logic [AMP_W-1:0] ramp_amp(input logic [AMP_W-1:0] base,
                                                  input logic [7:0] k);
        logic [63:0]      prod;
        logic [AMP_W-1:0] lim;
        prod = 64'({1'b0, k} + 9'd1) * 64'(RAMP_STEP);
        lim  = (prod > 64'({AMP_W{1'b1}})) ? {AMP_W{1'b1}} : AMP_W'(prod);
        return (base < lim) ? base : lim;
    endfunction

    assign phase_amp_d = start_c ? ramp_amp(amp_d, pulse_d) : pulse_amp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pulse_amp_q <= '0;
        else     pulse_amp_q <= phase_amp_d;
    end
`else
    assign phase_amp_d = amp_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ph_q          <= '0;
            pulse_q       <= '0;
            count_q       <= '0;
            amp_q         <= '0;
            abort_q       <= 1'b0;
            brake_dly_q   <= 1'b0;
            cath_en       <= 1'b0;
            anod_en       <= 1'b0;
            dac_code      <= '0;
            busy          <= 1'b0;
            stim_ack      <= 1'b0;
            train_done    <= 1'b0;
            train_aborted <= 1'b0;
        end else begin
            state_q       <= state_d;
            ph_q          <= ph_d;
            pulse_q       <= pulse_d;
            count_q       <= count_d;
            amp_q         <= amp_d;
            abort_q       <= abort_d;
            brake_dly_q   <= brake_active;
            cath_en       <= (state_d == ST_CATH);
            anod_en       <= (state_d == ST_ANOD);
            dac_code      <= (state_d == ST_CATH || state_d == ST_ANOD) ?
                             phase_amp_d : '0;
            busy          <= (state_d != ST_IDLE);
            stim_ack      <= ack_d;
            train_done    <= done_d;
            train_aborted <= aborted_d;
        end
    end

endmodule

// File: tb/tb_boreal_vns_pulse_ctrl.sv
// Run-length vector bench for boreal_vns_pulse_ctrl (PW=4, IPG=2, PERIOD=20,
// HOLDOFF=8, CAP=0x100); expected amplitudes follow VNS_RAMP_EN when defined.
module tb_boreal_vns_pulse_ctrl;

`ifdef VNS_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stim_req = 1'b0;
    logic [11:0] stim_amp = '0;
    logic [7:0]  stim_count = '0;
    logic        ad_guard_active = 1'b0;
    logic        cath_en, anod_en, busy, stim_ack, train_done, train_aborted, brake_active;
    logic [11:0] dac_code;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    boreal_vns_pulse_ctrl #(
        .PW_CYCLES(4), .IPG_CYCLES(2), .PERIOD_CYCLES(20), .AMP_W(12),
        .BRAKE_AMP_CAP(12'h100), .HOLDOFF_CYCLES(8), .RAMP_STEP(64)
    ) dut (
        .clk(clk), .rst(rst), .stim_req(stim_req), .stim_amp(stim_amp),
        .stim_count(stim_count), .ad_guard_active(ad_guard_active),
        .cath_en(cath_en), .anod_en(anod_en), .dac_code(dac_code), .busy(busy),
        .stim_ack(stim_ack), .train_done(train_done), .train_aborted(train_aborted),
        .brake_active(brake_active)
    );

    // Expected outputs packed as {cath, anod, dac[11:0], busy, ack, done, aborted, brake}
    typedef struct {
        string       tag;
        logic        req;
        logic [11:0] amp;
        logic [7:0]  cnt;
        logic        guard;
        int          reps;
        logic [18:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [11:0] exp_amp(input logic [11:0] base, input int k);
        int lim;
        lim = (k + 1) * 64;
        if (lim > 4095) lim = 4095;
        if (RAMP && lim < int'(base)) return 12'(lim);
        return base;
    endfunction

    function automatic logic [18:0] pk(input logic c, input logic a, input logic [11:0] d,
                                       input logic b, input logic k, input logic dn,
                                       input logic ab, input logic br);
        return {c, a, d, b, k, dn, ab, br};
    endfunction

    task automatic add(input string tag, input logic req, input logic [11:0] amp,
                       input logic [7:0] cnt, input logic g, input int reps,
                       input logic [18:0] exp);
        vec_t v;
        v.tag = tag; v.req = req; v.amp = amp; v.cnt = cnt;
        v.guard = g; v.reps = reps; v.exp = exp;
        vq.push_back(v);
    endtask

    // Remaining CATH cycles, gap, anodic phase and optional REST of one pulse
    task automatic add_pulse(input string tag, input logic [11:0] d, input logic g,
                             input logic br, input int cath_reps, input int rest_reps);
        if (cath_reps > 0) add({tag, "_cath"}, 0, 0, 0, g, cath_reps, pk(1, 0, d, 1, 0, 0, 0, br));
        add({tag, "_ipg"}, 0, 0, 0, g, 2, pk(0, 0, 0, 1, 0, 0, 0, br));
        add({tag, "_anod"}, 0, 0, 0, g, 4, pk(0, 1, d, 1, 0, 0, 0, br));
        if (rest_reps > 0) add({tag, "_rest"}, 0, 0, 0, g, rest_reps, pk(0, 0, 0, 1, 0, 0, 0, br));
    endtask

    task automatic check(input string tag, input logic [18:0] exp);
        logic [18:0] act;
        act = {cath_en, anod_en, dac_code, busy, stim_ack, train_done, train_aborted, brake_active};
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got {c,a,dac,busy,ack,done,abt,brk}=%h required %h",
                     tag, $time, act, exp);
        end
        if (cath_en === 1'b1 && anod_en === 1'b1) begin
            nerr++;
            $display("FAIL overlap %s @%0t: cath_en=1 anod_en=1 required not both", tag, $time);
        end
    endtask

    initial begin
        // Normal 3-pulse train; a request held high while busy must not be acked
        add("s1_acc", 1, 12'h300, 3, 0, 1, pk(1, 0, exp_amp(12'h300, 0), 1, 1, 0, 0, 0));
        add("s1_req_busy", 1, 12'h300, 3, 0, 3, pk(1, 0, exp_amp(12'h300, 0), 1, 0, 0, 0, 0));
        add_pulse("s1_p1", exp_amp(12'h300, 0), 0, 0, 0, 10);
        add_pulse("s1_p2", exp_amp(12'h300, 1), 0, 0, 4, 10);
        add_pulse("s1_p3", exp_amp(12'h300, 2), 0, 0, 4, 10);
        add("s1_done", 0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 1, 0, 0));
        // Zero-length train right after busy falls
        add("s2_cnt0", 1, 12'h055, 0, 0, 1, pk(0, 0, 0, 0, 1, 1, 0, 0));
        add("s2_idle", 0, 0, 0, 0, 2, pk(0, 0, 0, 0, 0, 0, 0, 0));
        // Guard rises in pulse 2 CATH: anodic completes, then abort skipping REST
        add("s3_acc", 1, 12'h300, 3, 0, 1, pk(1, 0, exp_amp(12'h300, 0), 1, 1, 0, 0, 0));
        add_pulse("s3_p1", exp_amp(12'h300, 0), 0, 0, 3, 10);
        add("s3_p2_c1", 0, 0, 0, 0, 1, pk(1, 0, exp_amp(12'h300, 1), 1, 0, 0, 0, 0));
        add_pulse("s3_p2", exp_amp(12'h300, 1), 1, 1, 3, 0);
        add("s3_abort", 0, 0, 0, 1, 1, pk(0, 0, 0, 0, 0, 0, 1, 1));
        add("s3_idle", 0, 0, 0, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 1));
        // Brake already active at acceptance: amplitude capped, no abort
        add("s4_acc", 1, 12'h300, 2, 1, 1, pk(1, 0, exp_amp(12'h100, 0), 1, 1, 0, 0, 1));
        add_pulse("s4_p1", exp_amp(12'h100, 0), 1, 1, 3, 10);
        add_pulse("s4_p2", exp_amp(12'h100, 1), 1, 1, 4, 10);
        add("s4_done", 0, 0, 0, 1, 1, pk(0, 0, 0, 0, 0, 1, 0, 1));
        // Hold-off restart: 7 low, 1 high, then 8 low to release
        add("s5_low7", 0, 0, 0, 0, 7, pk(0, 0, 0, 0, 0, 0, 0, 1));
        add("s5_hi", 0, 0, 0, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 1));
        add("s5_low7b", 0, 0, 0, 0, 7, pk(0, 0, 0, 0, 0, 0, 0, 1));
        add("s5_release", 0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 0));
        add("s5_idle", 0, 0, 0, 0, 2, pk(0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1 check("reset", pk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk) rst = 1'b0;

        foreach (vq[i]) begin
            stim_req        = vq[i].req;
            stim_amp        = vq[i].amp;
            stim_count      = vq[i].cnt;
            ad_guard_active = vq[i].guard;
            for (int r = 0; r < vq[i].reps; r++) begin
                @(posedge clk);
                #1 check(vq[i].tag, vq[i].exp);
            end
        end

        // Asynchronous reset in the middle of an anodic phase
        stim_req = 1'b1; stim_amp = 12'h200; stim_count = 8'd2; ad_guard_active = 1'b0;
        @(posedge clk);
        #1 stim_req = 1'b0;
        repeat (7) @(posedge clk);
        #1 check("rst_pre_anod", pk(0, 1, exp_amp(12'h200, 0), 1, 0, 0, 0, 0));
        #2 rst = 1'b1;
        #1 check("rst_async", pk(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 check("rst_held", pk(0, 0, 0, 0, 0, 0, 0, 0));
        #2 rst = 1'b0;
        @(posedge clk);
        #1 check("rst_idle", pk(0, 0, 0, 0, 0, 0, 0, 0));
        stim_req = 1'b1; stim_amp = 12'h050; stim_count = 8'd1;
        @(posedge clk);
        #1 check("post_rst_acc", pk(1, 0, exp_amp(12'h050, 0), 1, 1, 0, 0, 0));
        stim_req = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("post_rst_done", pk(0, 0, 0, 0, 0, 1, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
